bus_controller: RTL
===================

// Module: bus_controller
// PURPOSE
//  Parametrised 68000 bus controller: the next generation of the glue-logic system controller.
//  Provides CPU clock division, a boot overlay, region decode and chip selects.
//  Adds per-region DTACK wait-state generation, an NUM_IRQ-input interrupt priority encoder,
//  IACK routing with autovector (VPA) fallback, and an optional bus-error watchdog.
//  Sits between the CPU bus and the ROM/SRAM/DUART chip selects.
// PARAMETERS
//  CLK_DIV_LOG2   3   CLK_CPU = CLK / 2**CLK_DIV_LOG2 (range 1..4)
//  BOOT_CYCLES    4   completed bus cycles with the ROM overlay active (range 1..15)
//  ROM_WAIT       2   CLK cycles from synced AS-low to DTACK for ROM (range 0..15)
//  SRAM_WAIT      0   as ROM_WAIT, for SRAM
//  NUM_IRQ        7   interrupt inputs IRQ_N[NUM_IRQ:1]; level n = input n (range 1..7)
//  DUART_LEVEL    1   IPL level whose IACK is routed to the DUART
//  BERR_CYCLES    64  watchdog limit in CLK cycles (BERR_TIMEOUT_EN only)
// PORTS
//  CLK          in   1            source oscillator, 40 MHz
//  RST          in   1            asynchronous active-low reset
//  CLK_CPU      out  1            divided CPU clock
//  ADDR_H       in   10           A23..A14
//  ADDR_L       in   3            A3..A1 (IACK level during interrupt acknowledge)
//  AS,UDS,LDS   in   1 each       active-low strobes
//  RW           in   1            1 = read
//  FC           in   3            function code
//  IRQ_N        in   NUM_IRQ      active-low interrupt requests
//  DTACK_DUART  in   1            active-low DUART acknowledge
//  IPL          out  3            active-low encoded interrupt level
//  DTACK,VPA,BERR out 1 each      active-low CPU handshakes
//  ROM_LOWER,ROM_UPPER,SRAM_LOWER,SRAM_UPPER,DUART,IACK_DUART  out 1 each  active-low selects
//  BOOT         out  1            1 = overlay finished
// BEHAVIOUR
//  - Reset: all active-low outputs 1; BOOT=0; CLK_CPU=0; FSM=IDLE; boot count=0; divider=0.
//    Reset is asynchronous and may occur mid-cycle; it releases all handshakes immediately.
//  - AS, DTACK_DUART and IRQ_N are synchronised with 2 flops; all timing is relative to synced AS.
//  - Decode (IACK = FC==3'b111):
//      overlay while BOOT=0 -> ROM for every non-IACK address
//      ROM     0xE00000-0xEFFFFF
//      SRAM    0x000000-0x0FFFFF
//      DUART   0xC00000-0xCFFFFF (requires LDS low)
//      other   unmapped
//  - Selects are combinational: raw AS low AND region AND the matching UDS/LDS.
//    They drop the same cycle AS rises.
//  - FSM states and transitions:
//      IDLE -> WAIT on synced AS low; wait counter = region WAIT value
//      WAIT -> ACK when counter == 0 (decrement per CLK)
//        . DUART region: waits for synced DTACK_DUART low instead of the counter
//        . unmapped: stays in WAIT
//      ACK  -> drive DTACK=0 (or VPA=0); hold until synced AS high, then -> IDLE
//  - WAIT=0 gives DTACK 1 CLK after synced AS-low.
//  - IACK cycles:
//      ADDR_L == DUART_LEVEL -> IACK_DUART=0 and DTACK follows DTACK_DUART
//      otherwise -> VPA=0 after 1 CLK (autovector); DTACK stays 1
//  - Boot counter increments on each synced AS rising edge while BOOT=0.
//    BOOT is set when count reaches BOOT_CYCLES and is never cleared except by reset.
//    The cycle in progress when BOOT sets completes with its original decode.
//  - IPL is registered every CLK: ~(highest n with synced IRQ_N[n]==0), else 3'b111.
//    Simultaneous requests: the highest level wins. Level 7 gives IPL=3'b000.
//  - Divider: free-running CLK_DIV_LOG2-bit counter; CLK_CPU = MSB; wraps silently.
// CONFIGURATION
//  BERR_TIMEOUT_EN defined:
//    an 8-bit counter runs in WAIT
//    BERR=0 after BERR_CYCLES CLK with no acknowledge
//    held until synced AS high, then IDLE; DTACK is never asserted in the same cycle
//  BERR_TIMEOUT_EN undefined: BERR tied 1; an unmapped access hangs until reset.
// TESTING
//  1 Reset: hold RST low -> all selects/DTACK/VPA/BERR=1, IPL=3'b111, BOOT=0; async release.
//  2 Boot: 4 reads at 0x000000 -> ROM_LOWER/UPPER low, BOOT=1 after 4th AS rise;
//    5th read 0x000000 -> SRAM selects, DTACK 1 CLK after synced AS.
//  3 Wait states: ROM read 0xE00010, ROM_WAIT=2 -> DTACK low exactly 3 CLK after synced AS-low;
//    release within 1 CLK of synced AS high.
//  4 Interrupts: IRQ_N[3],[5] low -> IPL=3'b010; release [5] -> IPL=3'b100;
//    IACK level 3 -> VPA=0, DTACK=1; IACK level 1 -> IACK_DUART=0, DTACK tracks DTACK_DUART.
//  5 Watchdog: read 0x800000 with macro -> BERR=0 at CLK 64, DTACK=1;
//    without macro -> no response for 1000 CLK.
//  6 Reset during ROM WAIT -> DTACK stays 1, FSM IDLE, BOOT=0, boot count restarts.

Source files
------------

// File: rtl/bus_controller.sv
// 68000 bus controller: CPU clock divider, boot ROM overlay, region decode, chip selects,
// DTACK wait states, IRQ priority encoder, IACK routing. Optional watchdog: BERR_TIMEOUT_EN.
`timescale 1ns/1ps
module bus_controller #(
  parameter int CLK_DIV_LOG2 = 3,
  parameter int BOOT_CYCLES  = 4,
  parameter int ROM_WAIT     = 2,
  parameter int SRAM_WAIT    = 0,
  parameter int NUM_IRQ      = 7,
  parameter int DUART_LEVEL  = 1,
  parameter int BERR_CYCLES  = 64
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               CLK_CPU,
  input  logic [9:0]         ADDR_H,
  input  logic [2:0]         ADDR_L,
  input  logic               AS,
  input  logic               UDS,
  input  logic               LDS,
  input  logic               RW,
  input  logic [2:0]         FC,
  input  logic [NUM_IRQ:1]   IRQ_N,
  input  logic               DTACK_DUART,
  output logic [2:0]         IPL,
  output logic               DTACK,
  output logic               VPA,
  output logic               BERR,
  output logic               ROM_LOWER,
  output logic               ROM_UPPER,
  output logic               SRAM_LOWER,
  output logic               SRAM_UPPER,
  output logic               DUART,
  output logic               IACK_DUART,
  output logic               BOOT
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DTACK, S_VPA, S_BERR} state_e;
  typedef enum logic [2:0] {R_ROM, R_SRAM, R_DUART, R_IACK_DUART, R_IACK_AUTO, R_NONE} region_e;

  state_e                  state_q, state_d;
  region_e                 region_q, region_d, region_s;
  logic [3:0]              wait_q, wait_d;
  logic [3:0]              boot_cnt_q, boot_cnt_d;
  logic                    boot_q, boot_d;
  logic [CLK_DIV_LOG2-1:0] div_q, div_d;
  logic [2:0]              ipl_q, ipl_d;
  logic                    as_meta_q, as_sync_q, as_prev_q;
  logic                    dd_meta_q, dd_sync_q;
  logic [NUM_IRQ:1]        irq_meta_q, irq_sync_q;
  logic                    sel_en_s;
  logic                    unused_s;
`ifdef BERR_TIMEOUT_EN
  logic [7:0]              wd_q, wd_d;
`endif

  assign unused_s = ^{RW, ADDR_H[5:0]};

  // Two-flop synchronisers for the asynchronous CPU/peripheral inputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      as_meta_q  <= 1'b1;
      as_sync_q  <= 1'b1;
      as_prev_q  <= 1'b1;
      dd_meta_q  <= 1'b1;
      dd_sync_q  <= 1'b1;
      irq_meta_q <= '1;
      irq_sync_q <= '1;
    end else begin
      as_meta_q  <= AS;
      as_sync_q  <= as_meta_q;
      as_prev_q  <= as_sync_q;
      dd_meta_q  <= DTACK_DUART;
      dd_sync_q  <= dd_meta_q;
      irq_meta_q <= IRQ_N;
      irq_sync_q <= irq_meta_q;
    end
  end

  // Address decode; the overlay maps every non-IACK access to ROM until BOOT.
  always_comb begin
    region_s = R_NONE;
    if (FC == 3'b111) begin
      region_s = (ADDR_L == 3'(DUART_LEVEL)) ? R_IACK_DUART : R_IACK_AUTO;
    end else if (!boot_q) begin
      region_s = R_ROM;
    end else begin
      case (ADDR_H[9:6])
        4'hE:    region_s = R_ROM;
        4'h0:    region_s = R_SRAM;
        4'hC:    region_s = R_DUART;
        default: region_s = R_NONE;
      endcase
    end
  end

  // Selects follow raw AS so they drop the cycle AS rises; reset forces them inactive.
  assign sel_en_s   = RST & ~AS;
  assign ROM_UPPER  = ~(sel_en_s & (region_s == R_ROM)  & ~UDS);
  assign ROM_LOWER  = ~(sel_en_s & (region_s == R_ROM)  & ~LDS);
  assign SRAM_UPPER = ~(sel_en_s & (region_s == R_SRAM) & ~UDS);
  assign SRAM_LOWER = ~(sel_en_s & (region_s == R_SRAM) & ~LDS);
  assign DUART      = ~(sel_en_s & (region_s == R_DUART) & ~LDS);
  assign IACK_DUART = ~(sel_en_s & (region_s == R_IACK_DUART));

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      region_q <= R_NONE;
      wait_q   <= 4'd0;
`ifdef BERR_TIMEOUT_EN
      wd_q     <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wait_q   <= wait_d;
`ifdef BERR_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  // FSM next state. The IDLE->WAIT edge is itself the first wait clock, so a
  // region WAIT of N yields DTACK N+1 clocks after synced AS-low.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wait_d   = wait_q;
`ifdef BERR_TIMEOUT_EN
    wd_d     = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!as_sync_q) begin
          region_d = region_s;
`ifdef BERR_TIMEOUT_EN
          wd_d     = 8'd1;
`endif
          case (region_s)
            R_ROM, R_SRAM: begin
              wait_d  = (region_s == R_ROM) ? 4'(ROM_WAIT) : 4'(SRAM_WAIT);
              state_d = (wait_d == 4'd0) ? S_DTACK : S_WAIT;
            end
            R_IACK_AUTO: state_d = S_VPA;
            default:     state_d = S_WAIT;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        case (region_q)
          R_ROM, R_SRAM: begin
            if (wait_q <= 4'd1) state_d = S_DTACK;
            else                wait_d  = wait_q - 4'd1;
          end
          R_DUART, R_IACK_DUART: state_d = dd_sync_q ? S_WAIT : S_DTACK;
          default:               state_d = S_WAIT;
        endcase
`ifdef BERR_TIMEOUT_EN
        if ((state_d == S_WAIT) && (wd_q == 8'(BERR_CYCLES - 1))) state_d = S_BERR;
        else                                                        wd_d    = wd_q + 8'd1;
`endif
      end
      S_DTACK, S_VPA, S_BERR: state_d = as_sync_q ? S_IDLE : state_q;
      default:                state_d = S_IDLE;
    endcase
  end

  // FSM outputs: CPU handshakes decoded from the state register.
  always_comb begin
    DTACK = 1'b1;
    VPA   = 1'b1;
    BERR  = 1'b1;
    case (state_q)
      S_DTACK: DTACK = 1'b0;
      S_VPA:   VPA   = 1'b0;
      S_BERR: begin
`ifdef BERR_TIMEOUT_EN
        BERR = 1'b0;
`else
        BERR = 1'b1;
`endif
      end
      default: DTACK = 1'b1;
    endcase
  end

  // Boot counter, divider and interrupt level next values.
  always_comb begin
    boot_cnt_d = boot_cnt_q;
    boot_d     = boot_q;
    div_d      = div_q + {{(CLK_DIV_LOG2-1){1'b0}}, 1'b1};
    if (as_sync_q && !as_prev_q && !boot_q) begin
      boot_cnt_d = boot_cnt_q + 4'd1;
      boot_d     = (boot_cnt_q == 4'(BOOT_CYCLES - 1));
    end else begin
      boot_cnt_d = boot_cnt_q;
    end
    ipl_d = 3'b111;
    for (int n = 1; n <= NUM_IRQ; n++) begin
      ipl_d = irq_sync_q[n] ? ipl_d : ~3'(n);
    end
  end

  // Boot, divider and IPL registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      boot_cnt_q <= 4'd0;
      boot_q     <= 1'b0;
      div_q      <= '0;
      ipl_q      <= 3'b111;
    end else begin
      boot_cnt_q <= boot_cnt_d;
      boot_q     <= boot_d;
      div_q      <= div_d;
      ipl_q      <= ipl_d;
    end
  end

  assign BOOT    = boot_q;
  assign IPL     = ipl_q;
  assign CLK_CPU = div_q[CLK_DIV_LOG2-1];

endmodule
